mem_access_stage: RTL and testbench

//  MEM pipeline stage between the EX_MEM register and MEM_WB.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/mem_access_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   mem_state_e : access FSM states (IDLE / BUSY / DONE)
//   TIMER_W     : width of the access wait timer (covers TIMEOUT_CYC up to 1023)
//   ALIGN_MASK  : low address bits that must be zero for a word access
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int         TIMER_W    = 10;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage : mem_stage_pkg

// File: rtl/mem_wait_timer.sv
// Wait timer for an outstanding data-memory access.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the count with zero (wins over en)
//   en         : advance the count by one
//   tc         : terminal count, high while the count equals TIMEOUT_CYC-1
module mem_wait_timer
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT_CYC - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule : mem_wait_timer

// File: rtl/mem_access_stage.sv
// MEM pipeline stage between EX_MEM and MEM_WB.
// Issues loads/stores to an external data memory over a req/ack handshake of
// variable latency, stalls the upstream stages while an access is in flight,
// and passes non-memory instructions straight through with no added latency.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   MemRead/MemWrite               : EX_MEM access controls (both set = load)
//   RegWrite/MemtoReg/wn           : EX_MEM write-back controls and destination
//   ALUIn / WD                     : ALU result (byte address) / store data
//   dm_req/dm_we/dm_addr/dm_wdata  : registered memory request
//   dm_rdata/dm_ack                : memory response (ack is a 1-cycle pulse)
//   RDOut/ALUOut/O_wn/O_RegWrite/O_MemtoReg : towards MEM_WB
//   stall                          : freeze PC, IF_ID, ID_EX, EX_MEM
//   misalign / bus_err             : 1-cycle error pulses
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [4:0]  wn,
  input  logic [31:0] ALUIn,
  input  logic [31:0] WD,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] RDOut,
  output logic [31:0] ALUOut,
  output logic [4:0]  O_wn,
  output logic        O_RegWrite,
  output logic        O_MemtoReg,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  mem_state_e  state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        reg_write_q, reg_write_d;
  logic        memto_reg_q, memto_reg_d;
  logic [4:0]  wn_q, wn_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;

  logic        access;
  logic        misaligned;
  logic        timer_clr;
  logic        timer_en;
  logic        timer_tc;

  assign access     = MemRead | MemWrite;
  assign misaligned = |(ALUIn[1:0] & ALIGN_MASK);

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case statement can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    reg_write_d = reg_write_q;
    memto_reg_d = memto_reg_q;
    wn_d        = wn_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          state_d     = BUSY;
          dm_req_d    = 1'b1;
          // A combined read/write request is treated as a load.
          dm_we_d     = MemWrite & ~MemRead;
          dm_addr_d   = {ALUIn[31:2], 2'b00};
          dm_wdata_d  = WD;
          reg_write_d = RegWrite;
          memto_reg_d = MemtoReg;
          wn_d        = wn;
          alu_d       = ALUIn;
          // Cleared so stores and abandoned loads hand zero to MEM_WB.
          rdata_d     = '0;
          timer_clr   = 1'b1;
        end
      end
      BUSY: begin
        if (dm_ack) begin
          // An ack in the final allowed cycle still completes normally.
          if (!dm_we_q) begin
            rdata_d = dm_rdata;
          end
          dm_req_d = 1'b0;
          state_d  = DONE;
        end else if (timer_tc) begin
          dm_req_d    = 1'b0;
          bus_err_d   = 1'b1;
          reg_write_d = 1'b0;
          state_d     = DONE;
        end else begin
          timer_en = 1'b1;
        end
      end
      DONE: begin
        // MEM_WB takes the result at this edge; the next EX_MEM instruction
        // is only evaluated from IDLE in the following cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      wn_q        <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      wn_q        <= wn_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign bus_err  = bus_err_q;

  // Stage outputs: pass-through in IDLE, latched copies once an access has
  // been issued. A write-back is suppressed until the access has completed.
  always_comb begin
    ALUOut     = ALUIn;
    O_wn       = wn;
    O_RegWrite = RegWrite;
    O_MemtoReg = MemtoReg;
    RDOut      = '0;
    stall      = 1'b0;
    misalign   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          O_RegWrite = 1'b0;
          if (misaligned) begin
            misalign = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
      end
      BUSY: begin
        ALUOut     = alu_q;
        O_wn       = wn_q;
        O_RegWrite = 1'b0;
        O_MemtoReg = memto_reg_q;
        stall      = 1'b1;
      end
      DONE: begin
        ALUOut     = alu_q;
        O_wn       = wn_q;
        O_RegWrite = reg_write_q;
        O_MemtoReg = memto_reg_q;
        RDOut      = rdata_q;
      end
      default: begin
        O_RegWrite = 1'b0;
      end
    endcase

    // The pass-through paths are combinational, so they are forced quiet
    // while reset is held rather than relying on the IDLE state alone.
    if (!rst_n) begin
      stall      = 1'b0;
      O_RegWrite = 1'b0;
      O_MemtoReg = 1'b0;
      RDOut      = '0;
      misalign   = 1'b0;
    end
  end

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Each instruction is expanded by
// the bench into the cycle-by-cycle outputs it must produce (issue cycle,
// N wait cycles, completion cycle); a single compare process checks the DUT
// against that expectation queue on every falling edge.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write, reg_write, memto_reg;
  logic [4:0]  wn;
  logic [31:0] alu_in, wd;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic [31:0] rd_out, alu_out;
  logic [4:0]  o_wn;
  logic        o_reg_write, o_memto_reg, stall, misalign, bus_err;

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (mem_read),
    .MemWrite   (mem_write),
    .RegWrite   (reg_write),
    .MemtoReg   (memto_reg),
    .wn         (wn),
    .ALUIn      (alu_in),
    .WD         (wd),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack),
    .RDOut      (rd_out),
    .ALUOut     (alu_out),
    .O_wn       (o_wn),
    .O_RegWrite (o_reg_write),
    .O_MemtoReg (o_memto_reg),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          stall;
    bit          req;
    bit          we;
    bit          rw;
    bit          mis;
    bit          berr;
    bit          chk_out;
    bit          m2r;
    logic [4:0]  wn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_checks = 0;
  int   n_errors = 0;

  // Per-instruction observations used by the literal checks.
  int          n_stall;
  bit          req_seen, we_seen, mis_seen;
  logic [31:0] s_rd, s_alu, s_wdata;
  logic [4:0]  s_wn;
  logic        s_rw, s_m2r, s_berr, s_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t pass_exp(bit rw, bit m2r, logic [4:0] w, logic [31:0] a);
    exp_t e;
    e = '{default: '0};
    e.rw = rw; e.m2r = m2r; e.wn = w; e.alu = a; e.chk_out = 1'b1;
    return e;
  endfunction

  // Compare process: one expectation per clock cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      check("stall", {31'd0, stall}, {31'd0, ce.stall});
      check("dm_req", {31'd0, dm_req}, {31'd0, ce.req});
      check("O_RegWrite", {31'd0, o_reg_write}, {31'd0, ce.rw});
      check("misalign", {31'd0, misalign}, {31'd0, ce.mis});
      check("bus_err", {31'd0, bus_err}, {31'd0, ce.berr});
      if (ce.req) begin
        check("dm_we", {31'd0, dm_we}, {31'd0, ce.we});
        check("dm_addr", dm_addr, ce.addr);
        check("dm_wdata", dm_wdata, ce.wdata);
      end
      if (ce.chk_out) begin
        check("ALUOut", alu_out, ce.alu);
        check("O_wn", {27'd0, o_wn}, {27'd0, ce.wn});
        check("O_MemtoReg", {31'd0, o_memto_reg}, {31'd0, ce.m2r});
        check("RDOut", rd_out, ce.rd);
      end
    end
  end

  // One clock cycle: queue the expectation, sample at the falling edge,
  // then move to just after the next rising edge.
  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
    n_stall  += int'(stall);
    req_seen |= dm_req;
    we_seen  |= dm_req & dm_we;
    mis_seen |= misalign;
    if (dm_req) s_wdata = dm_wdata;
    s_rd = rd_out; s_alu = alu_out; s_wn = o_wn; s_rw = o_reg_write;
    s_m2r = o_memto_reg; s_berr = bus_err; s_stall = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    mem_read  = 1'($urandom_range(0, 1));
    mem_write = 1'($urandom_range(0, 1));
    reg_write = 1'($urandom_range(0, 1));
    memto_reg = 1'($urandom_range(0, 1));
    wn        = 5'($urandom);
    alu_in    = $urandom;
    wd        = $urandom;
  endtask

  // Present one EX_MEM instruction and run it to completion.
  // ack_k: BUSY cycle (1-based) in which dm_ack pulses; outside 1..TO means
  // no ack, so the access times out. stray: dm_ack level outside BUSY.
  task automatic run_ins(input bit mr, input bit mw, input bit rw, input bit m2r,
                         input logic [4:0] w, input logic [31:0] a, input logic [31:0] d,
                         input int ack_k, input logic [31:0] rdat, input bit stray);
    exp_t e;
    bit   is_load, tout;
    int   n;
    n_stall = 0; req_seen = 0; we_seen = 0; mis_seen = 0;
    mem_read = mr; mem_write = mw; reg_write = rw; memto_reg = m2r;
    wn = w; alu_in = a; wd = d; dm_ack = stray; dm_rdata = $urandom;
    e = pass_exp(rw, m2r, w, a);
    if (!(mr | mw)) begin
      step(e);
    end else if (a[1:0] != 2'b00) begin
      e.rw = 1'b0; e.mis = 1'b1;
      step(e);
    end else begin
      is_load = mr;
      tout    = !(ack_k >= 1 && ack_k <= int'(TO));
      n       = tout ? int'(TO) : ack_k;
      e.stall = 1'b1; e.rw = 1'b0; e.chk_out = 1'b0;
      step(e);
      e.req = 1'b1; e.we = !is_load; e.addr = a; e.wdata = d;
      for (int j = 1; j <= n; j++) begin
        scramble_inputs();
        dm_ack   = (j == ack_k);
        dm_rdata = (j == ack_k) ? rdat : $urandom;
        step(e);
      end
      scramble_inputs();
      dm_ack = stray; dm_rdata = $urandom;
      e = pass_exp(rw && !tout, m2r, w, a);
      e.rd   = (is_load && !tout) ? rdat : 32'd0;
      e.berr = tout;
      step(e);
      // The stage has retired the instruction; EX_MEM moves on.
      mem_read = 1'b0; mem_write = 1'b0; dm_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   r, k;
    bit   mr, mw, rw;
    logic [31:0] a;

    // Reset held with an aligned load on the inputs and ack high.
    rst_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; memto_reg = 1'b1;
    wn = 5'd3; alu_in = 32'h40; wd = 32'h1111_2222; dm_rdata = 32'hFFFF_FFFF; dm_ack = 1'b1;
    @(posedge clk); #1;
    e = '{default: '0};
    step(e);
    check("rst O_MemtoReg", {31'd0, s_m2r}, 32'd0);
    check("rst RDOut", s_rd, 32'd0);
    check("rst dm_we", {31'd0, dm_we}, 32'd0);
    check("rst dm_addr", dm_addr, 32'd0);
    check("rst dm_wdata", dm_wdata, 32'd0);
    step(e);
    rst_n = 1'b1;

    // ALU op, no memory access.
    run_ins(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_1234, 32'h0, 0, 32'h0, 1'b0);
    check("alu O_RegWrite", {31'd0, s_rw}, 32'd1);
    check("alu ALUOut", s_alu, 32'h0000_1234);
    check("alu stall cycles", n_stall, 0);
    check("alu dm_req seen", {31'd0, req_seen}, 32'd0);

    // Load 0x100, ack in the 3rd BUSY cycle.
    run_ins(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    check("load stall cycles", n_stall, 4);
    check("load RDOut", s_rd, 32'hDEAD_BEEF);
    check("load O_RegWrite", {31'd0, s_rw}, 32'd1);
    check("load O_MemtoReg", {31'd0, s_m2r}, 32'd1);
    check("load O_wn", {27'd0, s_wn}, 32'd7);

    // Store 0x200, ack in the first BUSY cycle.
    run_ins(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0200, 32'hA5A5_A5A5, 1, 32'h1234_5678, 1'b0);
    check("store stall cycles", n_stall, 2);
    check("store dm_we seen", {31'd0, we_seen}, 32'd1);
    check("store dm_wdata", s_wdata, 32'hA5A5_A5A5);
    check("store O_RegWrite", {31'd0, s_rw}, 32'd0);
    check("store RDOut", s_rd, 32'd0);

    // Misaligned load.
    run_ins(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0102, 32'h0, 1, 32'h0, 1'b0);
    check("misalign seen", {31'd0, mis_seen}, 32'd1);
    check("misalign dm_req seen", {31'd0, req_seen}, 32'd0);
    check("misalign stall cycles", n_stall, 0);
    check("misalign O_RegWrite", {31'd0, s_rw}, 32'd0);

    // Ack in the last allowed BUSY cycle still completes.
    run_ins(1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_0ABC, 32'h0, int'(TO), 32'h0BAD_F00D, 1'b0);
    check("late ack bus_err", {31'd0, s_berr}, 32'd0);
    check("late ack RDOut", s_rd, 32'h0BAD_F00D);

    // Timeout: no ack; stray ack in the DONE cycle and the next instruction.
    run_ins(1'b1, 1'b0, 1'b1, 1'b1, 5'd21, 32'h0000_0300, 32'h0, 0, 32'h0, 1'b1);
    check("timeout stall cycles", n_stall, int'(TO) + 1);
    check("timeout bus_err", {31'd0, s_berr}, 32'd1);
    check("timeout O_RegWrite", {31'd0, s_rw}, 32'd0);
    run_ins(1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0000_0055, 32'h0, 0, 32'h0, 1'b1);
    check("stray ack dm_req seen", {31'd0, req_seen}, 32'd0);
    check("stray ack bus_err", {31'd0, s_berr}, 32'd0);

    // Reset asserted during the 2nd BUSY cycle of a load.
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; memto_reg = 1'b1;
    wn = 5'd5; alu_in = 32'h0000_0400; wd = 32'h0; dm_ack = 1'b0;
    e = pass_exp(1'b0, 1'b1, 5'd5, 32'h400);
    e.stall = 1'b1; e.chk_out = 1'b0;
    step(e);
    e.req = 1'b1; e.we = 1'b0; e.addr = 32'h400; e.wdata = 32'h0;
    step(e);
    rst_n = 1'b0;
    e = '{default: '0};
    step(e);
    check("mid rst stall", {31'd0, s_stall}, 32'd0);
    check("mid rst dm_req", {31'd0, dm_req}, 32'd0);
    check("mid rst O_MemtoReg", {31'd0, s_m2r}, 32'd0);
    step(e);
    rst_n = 1'b1;
    run_ins(1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0777, 32'h0, 0, 32'h0, 1'b1);
    check("post rst ack dm_req seen", {31'd0, req_seen}, 32'd0);
    run_ins(1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 32'h0000_0778, 32'h0, 0, 32'h0, 1'b0);
    check("post rst bus_err", {31'd0, s_berr}, 32'd0);

    // Randomized mix.
    for (int i = 0; i < 200; i++) begin
      r  = int'($urandom_range(0, 9));
      a  = $urandom & 32'hFFFF_FFFC;
      rw = 1'($urandom_range(0, 1));
      mr = 1'b0; mw = 1'b0;
      if (r >= 3 && r <= 5) mr = 1'b1;
      else if (r == 6 || r == 7) begin mw = 1'b1; rw = 1'b0; end
      else if (r == 8) begin mr = 1'b1; mw = 1'b1; end
      else if (r == 9) begin
        mr = 1'($urandom_range(0, 1)); mw = !mr;
        if (mw) rw = 1'b0;
        a[1:0] = 2'($urandom_range(1, 3));
      end
      k = int'($urandom_range(0, TO));
      run_ins(mr, mw, rw, 1'($urandom_range(0, 1)), 5'($urandom), a, $urandom,
              k, $urandom, 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_access_stage
